nibble_parity_checker: RTL and testbench
========================================

NIBBLE_PARITY_CHECKER -- requirements
Module: nibble_parity_checker

Interface
REQ-001 The block SHALL have parameter CNT_W, default 8, giving the error-counter width (legal range 1..16).
REQ-002 The block SHALL have port CLK, input, 1 bit: the single clock; all state is updated on the rising edge.
REQ-003 The block SHALL have port RST_N, input, 1 bit: reset, asynchronous and active-low.
REQ-004 The block SHALL have port I_VALID, input, 1 bit: an input word is offered.
REQ-005 The block SHALL have port I_READY, output, 1 bit: the block can accept an input word.
REQ-006 The block SHALL have port I_DP, input, 5 bits: {parity, D[3:0]} as produced by the nibble parity generator.
REQ-007 The block SHALL have port I_EN, input, 4 bits: per-bit parity-enable mask that applied when I_DP was generated.
REQ-008 The block SHALL have port CLR, input, 1 bit: synchronous clear of the error statistics.
REQ-009 The block SHALL have port O_VALID, output, 1 bit: a checked word is presented.
REQ-010 The block SHALL have port O_READY, input, 1 bit: the downstream consumer accepts the presented word.
REQ-011 The block SHALL have port O_D, output, 4 bits: the data nibble of the presented word.
REQ-012 The block SHALL have port O_ERR, output, 1 bit: the presented word failed its parity check.
REQ-013 The block SHALL have port ERR_CNT, output, CNT_W bits: saturating count of failed words.
REQ-014 The block SHALL have port ERR_STICKY, output, 1 bit: at least one failure has occurred since reset or the last CLR.

Function
REQ-015 The expected parity SHALL be the XOR over i=0..3 of (I_DP[i] AND I_EN[i]), i.e. even parity with seed 0; I_EN=0000 gives expected parity 0.
REQ-016 An accepted word SHALL be flagged err = expected parity XOR I_DP[4].
REQ-017 A word SHALL be accepted in a cycle where I_VALID=1 and I_READY=1, and SHALL be delivered in a cycle where O_VALID=1 and O_READY=1.
REQ-018 The output buffer SHALL hold 2 entries of {D, err} and operate in FIFO order.
REQ-019 I_READY SHALL be 1 whenever the occupancy is below 2, SHALL be driven from a register, and SHALL NOT depend combinationally on O_READY.
REQ-020 Latency SHALL be 1 cycle: a word accepted into an empty buffer at edge N is presented with O_VALID=1 after edge N.
REQ-021 A simultaneous accept and deliver SHALL leave the occupancy unchanged and preserve FIFO order.
REQ-022 While O_VALID=1 and O_READY=0, O_D and O_ERR SHALL remain stable.
REQ-023 When the buffer is empty, O_VALID SHALL be 0 and O_D/O_ERR SHALL hold their last value (0 after reset).
REQ-024 ERR_CNT SHALL increment on each accepted word with err=1 and SHALL saturate at 2^CNT_W-1 without wrapping.
REQ-025 ERR_STICKY SHALL set on the first accepted word with err=1.
REQ-026 CLR SHALL zero ERR_CNT and ERR_STICKY on the next edge.
REQ-027 When CLR coincides with the acceptance of an erroneous word, the result SHALL be ERR_CNT=1 and ERR_STICKY=1, so no event is lost.
REQ-028 CLR SHALL NOT affect the buffer or the handshake.

Reset
REQ-029 While RST_N=0, the block SHALL immediately force occupancy=0, O_VALID=0, O_D=0, O_ERR=0, ERR_CNT=0, ERR_STICKY=0 and I_READY=0.
REQ-030 I_READY SHALL rise on the first CLK edge after RST_N deasserts.
REQ-031 Reset asserted mid-transfer SHALL discard all buffered words; no partial word SHALL be presented after release.

Structure
REQ-032 Package nibble_parity_pkg SHALL hold NIB_W=4, DP_W=5, the {D, err} entry typedef, and a parity function shared with the generator side.
REQ-033 The 2-entry buffer SHALL be the sub-module parity_skid_buf, parameterised by entry width.
REQ-034 Parity computation, statistics and CLR handling SHALL reside in the top module.

Verification
REQ-035 The bench SHALL cover this scenario: I_DP=1_0111, I_EN=1111, O_READY=1 -> one cycle later O_VALID=1, O_D=0111, O_ERR=0, and ERR_CNT stays 0.
REQ-036 The bench SHALL cover this scenario: I_DP=0_0011, I_EN=0001 -> O_ERR=1, ERR_CNT=1, ERR_STICKY=1.
REQ-037 The bench SHALL cover this scenario: O_READY=0 and 3 words offered back-to-back -> 2 accepted, I_READY=0 on the third, O_D stable; then O_READY=1 -> words delivered in order and the third accepted.
REQ-038 The bench SHALL cover this scenario: CNT_W=2 and 5 erroneous words -> ERR_CNT sequence 1,2,3,3,3.
REQ-039 The bench SHALL cover this scenario: CLR in the same cycle as acceptance of an erroneous word, starting from ERR_CNT=3 -> ERR_CNT=1, ERR_STICKY=1.
REQ-040 The bench SHALL cover this scenario: RST_N pulsed low with 2 words buffered -> O_VALID=0 immediately, and after release I_READY=1 with nothing delivered.

Source files
------------

// File: rtl/nibble_parity_pkg.sv
// Shared definitions for the nibble parity generator/checker pair.
package nibble_parity_pkg;

   localparam int unsigned NIB_W   = 4;
   localparam int unsigned DP_W    = NIB_W + 1;
   localparam int unsigned ENTRY_W = NIB_W + 1;

   // One buffered word: data nibble plus its parity-check verdict.
   typedef struct packed {
      logic [NIB_W-1:0] d;
      logic             err;
   } entry_t;

   // Even parity (seed 0) over the enabled data bits; an all-zero mask gives 0.
   function automatic logic nib_parity(input logic [NIB_W-1:0] d,
                                       input logic [NIB_W-1:0] en);
      return ^(d & en);
   endfunction

endpackage

// File: rtl/parity_skid_buf.sv
// Two-entry FIFO with a registered head and a registered input ready.
module parity_skid_buf #(
   parameter int unsigned EntryW = 5
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              in_valid_i,
   output logic              in_ready_o,
   input  logic [EntryW-1:0] in_data_i,
   output logic              out_valid_o,
   input  logic              out_ready_i,
   output logic [EntryW-1:0] out_data_o
);

   logic [1:0]        count_d, count_q;
   logic [EntryW-1:0] head_d, head_q;
   logic [EntryW-1:0] skid_d, skid_q;
   logic              ready_d, ready_q;
   logic              push, pop;

   assign push        = in_valid_i & ready_q;
   assign pop         = (count_q != 2'd0) & out_ready_i;
   assign in_ready_o  = ready_q;
   assign out_valid_o = (count_q != 2'd0);
   assign out_data_o  = head_q;

   // Next-state for occupancy and storage; the head keeps its last value when empty.
   always_comb begin
      count_d = count_q;
      head_d  = head_q;
      skid_d  = skid_q;
      unique case (count_q)
         2'd0: begin
            if (push) begin
               head_d  = in_data_i;
               count_d = 2'd1;
            end
         end
         2'd1: begin
            if (push && pop) begin
               head_d = in_data_i;
            end else if (push) begin
               skid_d  = in_data_i;
               count_d = 2'd2;
            end else if (pop) begin
               count_d = 2'd0;
            end
         end
         default: begin
            // Ready is low when full, so only a pop can happen here.
            if (pop) begin
               head_d  = skid_q;
               count_d = 2'd1;
            end
         end
      endcase
      // Registered ready looks at next occupancy, never at out_ready_i directly.
      ready_d = (count_d != 2'd2);
   end

   // State registers; reset discards every buffered word and drops ready.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         count_q <= 2'd0;
         head_q  <= '0;
         skid_q  <= '0;
         ready_q <= 1'b0;
      end else begin
         count_q <= count_d;
         head_q  <= head_d;
         skid_q  <= skid_d;
         ready_q <= ready_d;
      end
   end

endmodule

// File: rtl/nibble_parity_checker.sv
// Checks nibble parity, buffers {D, err} two deep and keeps error statistics.
module nibble_parity_checker
   import nibble_parity_pkg::*;
#(
   parameter int unsigned CNT_W = 8
) (
   input  logic             CLK,
   input  logic             RST_N,
   input  logic             I_VALID,
   output logic             I_READY,
   input  logic [DP_W-1:0]  I_DP,
   input  logic [NIB_W-1:0] I_EN,
   input  logic             CLR,
   output logic             O_VALID,
   input  logic             O_READY,
   output logic [NIB_W-1:0] O_D,
   output logic             O_ERR,
   output logic [CNT_W-1:0] ERR_CNT,
   output logic             ERR_STICKY
);

   entry_t           in_entry, out_entry;
   logic             accept, bad_accept;
   logic [CNT_W-1:0] err_cnt_d, err_cnt_q;
   logic             sticky_d, sticky_q;

   // Verdict for the offered word: expected parity against the received parity bit.
   always_comb begin
      in_entry.d   = I_DP[NIB_W-1:0];
      in_entry.err = nib_parity(I_DP[NIB_W-1:0], I_EN) ^ I_DP[DP_W-1];
   end

   parity_skid_buf #(
      .EntryW (ENTRY_W)
   ) u_buf (
      .clk_i       (CLK),
      .rst_ni      (RST_N),
      .in_valid_i  (I_VALID),
      .in_ready_o  (I_READY),
      .in_data_i   (in_entry),
      .out_valid_o (O_VALID),
      .out_ready_i (O_READY),
      .out_data_o  (out_entry)
   );

   assign O_D        = out_entry.d;
   assign O_ERR      = out_entry.err;
   assign accept     = I_VALID & I_READY;
   assign bad_accept = accept & in_entry.err;
   assign ERR_CNT    = err_cnt_q;
   assign ERR_STICKY = sticky_q;

   // Statistics next-state; a clear that meets a new error still records that error.
   always_comb begin
      err_cnt_d = err_cnt_q;
      sticky_d  = sticky_q;
      if (CLR) begin
         err_cnt_d = bad_accept ? CNT_W'(1) : '0;
         sticky_d  = bad_accept;
      end else if (bad_accept) begin
         sticky_d = 1'b1;
         if (err_cnt_q != {CNT_W{1'b1}}) begin
            err_cnt_d = err_cnt_q + CNT_W'(1);
         end
      end
   end

   // Statistics registers.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         err_cnt_q <= '0;
         sticky_q  <= 1'b0;
      end else begin
         err_cnt_q <= err_cnt_d;
         sticky_q  <= sticky_d;
      end
   end

endmodule

// File: tb/tb_nibble_parity_checker.sv
// Directed bench for nibble_parity_checker with a 2-bit error counter.
module tb_nibble_parity_checker;

   logic       CLK = 1'b0;
   logic       RST_N;
   logic       I_VALID;
   logic       I_READY;
   logic [4:0] I_DP;
   logic [3:0] I_EN;
   logic       CLR;
   logic       O_VALID;
   logic       O_READY;
   logic [3:0] O_D;
   logic       O_ERR;
   logic [1:0] ERR_CNT;
   logic       ERR_STICKY;

   int n_checks = 0;
   int n_errors = 0;

   nibble_parity_checker #(
      .CNT_W (2)
   ) dut (
      .CLK        (CLK),
      .RST_N      (RST_N),
      .I_VALID    (I_VALID),
      .I_READY    (I_READY),
      .I_DP       (I_DP),
      .I_EN       (I_EN),
      .CLR        (CLR),
      .O_VALID    (O_VALID),
      .O_READY    (O_READY),
      .O_D        (O_D),
      .O_ERR      (O_ERR),
      .ERR_CNT    (ERR_CNT),
      .ERR_STICKY (ERR_STICKY)
   );

   always #5 CLK = ~CLK;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Advance one edge and settle just after it.
   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   // Error counter expected after each of five erroneous words with CNT_W=2.
   logic [1:0] sat_seq [5] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};

   initial begin
      RST_N   = 1'b0;
      I_VALID = 1'b0;
      I_DP    = '0;
      I_EN    = '0;
      CLR     = 1'b0;
      O_READY = 1'b0;
      #2;
      check("rst_o_valid", O_VALID, 0);
      check("rst_i_ready", I_READY, 0);
      check("rst_o_d", O_D, 0);
      check("rst_o_err", O_ERR, 0);
      check("rst_err_cnt", ERR_CNT, 0);
      check("rst_sticky", ERR_STICKY, 0);
      tick();
      tick();
      @(negedge CLK);
      RST_N = 1'b1;
      #1;
      check("ready_before_edge", I_READY, 0);
      tick();
      check("ready_after_release", I_READY, 1);

      // Good word, all bits enabled: parity of 0111 is 1, matches bit 4.
      O_READY = 1'b1;
      I_VALID = 1'b1;
      I_DP    = 5'b1_0111;
      I_EN    = 4'b1111;
      tick();
      I_VALID = 1'b0;
      check("good_o_valid", O_VALID, 1);
      check("good_o_d", O_D, 4'b0111);
      check("good_o_err", O_ERR, 0);
      check("good_err_cnt", ERR_CNT, 0);
      tick();
      check("drain_o_valid", O_VALID, 0);
      check("hold_o_d", O_D, 4'b0111);

      // Only bit 0 enabled: expected parity 1 but bit 4 is 0.
      I_VALID = 1'b1;
      I_DP    = 5'b0_0011;
      I_EN    = 4'b0001;
      tick();
      I_VALID = 1'b0;
      check("bad_o_err", O_ERR, 1);
      check("bad_o_d", O_D, 4'b0011);
      check("bad_err_cnt", ERR_CNT, 1);
      check("bad_sticky", ERR_STICKY, 1);
      tick();

      // Plain clear.
      CLR = 1'b1;
      tick();
      CLR = 1'b0;
      check("clr_err_cnt", ERR_CNT, 0);
      check("clr_sticky", ERR_STICKY, 0);

      // Backpressure: three words offered, two fit. Mask 0000 -> expected parity 0.
      O_READY = 1'b0;
      I_EN    = 4'b0000;
      I_VALID = 1'b1;
      I_DP    = 5'b0_0001;
      tick();
      I_DP    = 5'b0_0010;
      tick();
      I_DP    = 5'b0_0100;
      check("full_i_ready", I_READY, 0);
      check("full_o_d", O_D, 4'b0001);
      tick();
      check("stall_i_ready", I_READY, 0);
      check("stall_o_d", O_D, 4'b0001);
      check("stall_o_valid", O_VALID, 1);
      O_READY = 1'b1;
      tick();
      check("order_second", O_D, 4'b0010);
      check("reopen_i_ready", I_READY, 1);
      tick();
      I_VALID = 1'b0;
      check("order_third", O_D, 4'b0100);
      check("order_third_valid", O_VALID, 1);
      check("order_err_flag", O_ERR, 0);
      tick();
      check("order_empty", O_VALID, 0);
      check("order_err_cnt", ERR_CNT, 0);

      // Saturation: mask 0000 with parity bit 1 is always an error.
      I_VALID = 1'b1;
      I_DP    = 5'b1_0000;
      for (int i = 0; i < 5; i++) begin
         tick();
         check($sformatf("sat_cnt_%0d", i), ERR_CNT, sat_seq[i]);
      end
      check("sat_o_err", O_ERR, 1);

      // Clear colliding with an erroneous accept, from a saturated count.
      CLR  = 1'b1;
      I_DP = 5'b0_1000;
      I_EN = 4'b1000;
      tick();
      I_VALID = 1'b0;
      check("clr_hit_cnt", ERR_CNT, 1);
      check("clr_hit_sticky", ERR_STICKY, 1);
      check("clr_hit_o_d", O_D, 4'b1000);
      tick();
      CLR = 1'b0;
      check("clr_again_cnt", ERR_CNT, 0);
      check("clr_again_sticky", ERR_STICKY, 0);
      tick();

      // Reset with two words buffered.
      O_READY = 1'b0;
      I_EN    = 4'b0000;
      I_VALID = 1'b1;
      I_DP    = 5'b0_0101;
      tick();
      I_DP    = 5'b0_0110;
      tick();
      I_VALID = 1'b0;
      check("pre_rst_valid", O_VALID, 1);
      #2;
      RST_N = 1'b0;
      #1;
      check("mid_rst_o_valid", O_VALID, 0);
      check("mid_rst_i_ready", I_READY, 0);
      check("mid_rst_o_d", O_D, 0);
      @(negedge CLK);
      RST_N   = 1'b1;
      O_READY = 1'b1;
      tick();
      check("post_rst_i_ready", I_READY, 1);
      check("post_rst_o_valid", O_VALID, 0);
      tick();
      check("post_rst_nothing", O_VALID, 0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
